// File: rtl/uart_mem_master.sv
// Host-side initiator for the byte-level UART memory-access protocol: one read/write in flight,
// command/data bytes out on tx, read response in on rx. Optional macro: UART_MEM_MASTER_TIMEOUT_EN.
module uart_mem_master #(
  parameter int AddrWidth     = 7,
  parameter int DataSize      = 8,
  parameter int TimeoutCycles = 1000000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_write,
  input  logic [AddrWidth-1:0] i_req_addr,
  input  logic [DataSize-1:0]  i_req_wdata,
  output logic                 o_rsp_valid,
  output logic [DataSize-1:0]  o_rsp_rdata,
  output logic                 o_rsp_timeout,
  output logic [DataSize-1:0]  o_tx_data,
  output logic                 o_tx_data_valid,
  input  logic                 i_tx_data_ready,
  input  logic [DataSize-1:0]  i_rx_data,
  input  logic                 i_rx_data_valid,
  output logic                 o_rx_data_ready
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    SEND_DATA,
    WAIT_RSP,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic                 write_q, write_d;
  logic [DataSize-1:0]  wdata_q, wdata_d;
  logic                 req_ready_q, req_ready_d;
  logic                 rx_ready_q, rx_ready_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [DataSize-1:0]  tx_data_q, tx_data_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DataSize-1:0]  rdata_q, rdata_d;
  logic                 timeout_q, timeout_d;
  logic                 expired;

`ifdef UART_MEM_MASTER_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired = (state_q == WAIT_RSP) && (cnt_q == CntLast);

  // Held at zero while the command is on the wire, so WAIT_RSP always starts from 0.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SEND_CMD) begin
      cnt_d = '0;
    end else if (state_q == WAIT_RSP && cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign expired = 1'b0;
`endif

  // NOTE: every variable gets a default before the case, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    tx_data_d = tx_data_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;

    case (state_q)
      IDLE: begin
        // Stray rx bytes are accepted here (ready is high) and simply dropped.
        if (i_req_valid && req_ready_q) begin
          state_d   = SEND_CMD;
          write_d   = i_req_write;
          wdata_d   = i_req_wdata;
          tx_data_d = DataSize'({i_req_write, i_req_addr});
        end
      end
      SEND_CMD: begin
        if (i_tx_data_ready) begin
          if (write_q) begin
            state_d   = SEND_DATA;
            tx_data_d = wdata_q;
          end else begin
            state_d = WAIT_RSP;
          end
        end
      end
      SEND_DATA: begin
        if (i_tx_data_ready) begin
          state_d   = DONE;
          rdata_d   = '0;
          timeout_d = 1'b0;
        end
      end
      WAIT_RSP: begin
        // A byte landing on the expiry edge still wins over the timeout.
        if (i_rx_data_valid) begin
          state_d   = DONE;
          rdata_d   = i_rx_data;
          timeout_d = 1'b0;
        end else if (expired) begin
          state_d   = DONE;
          rdata_d   = '0;
          timeout_d = 1'b1;
        end
      end
      DONE: begin
        state_d   = IDLE;
        timeout_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they line up with the state.
    req_ready_d = (state_d == IDLE);
    rx_ready_d  = (state_d == IDLE) || (state_d == WAIT_RSP);
    tx_valid_d  = (state_d == SEND_CMD) || (state_d == SEND_DATA);
    rsp_valid_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      req_ready_q <= 1'b0;
      rx_ready_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rx_ready_q  <= rx_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_req_ready     = req_ready_q;
  assign o_rx_data_ready = rx_ready_q;
  assign o_tx_data_valid = tx_valid_q;
  assign o_tx_data       = tx_data_q;
  assign o_rsp_valid     = rsp_valid_q;
  assign o_rsp_rdata     = rdata_q;
  assign o_rsp_timeout   = timeout_q;

endmodule
